arbitro_rr_fifo: RTL
====================

// Module: arbitro_rr_fifo
// PURPOSE
//  Round-robin arbiter/router between 4 upstream FIFOs and 4 downstream FIFOs.
//  Pops one word per cycle from a non-empty upstream FIFO and pushes it into the
//  downstream FIFO selected by the word's 2 MSBs (destination field).
//  Stalls all pops while any downstream FIFO reports almost_full (backpressure).
// PARAMETERS
//  WORD_SIZE  6  data word width; bits [WORD_SIZE-1:WORD_SIZE-2] = destination 0..3
// PORTS
//  clk            in   1          single clock, all state on posedge
//  reset          in   1          synchronous, active-high
//  fifo_empty     in   4          empty flags of upstream FIFOs 0..3
//  fifo_data_out0 in   WORD_SIZE  upstream FIFO0 read data (valid cycle after its rd)
//  fifo_data_out1 in   WORD_SIZE  upstream FIFO1 read data
//  fifo_data_out2 in   WORD_SIZE  upstream FIFO2 read data
//  fifo_data_out3 in   WORD_SIZE  upstream FIFO3 read data
//  almost_full    in   4          almost_full flags of downstream FIFOs 0..3
//  fifo_full      in   4          full flags of downstream FIFOs 0..3
//  fifo_rd        out  4          one-hot pop to upstream FIFOs (at most one bit set)
//  fifo_wr        out  4          one-hot push to downstream FIFOs
//  fifo_data_in   out  WORD_SIZE  word pushed downstream
//  error          out  1          sticky: push attempted into a full downstream FIFO
// BEHAVIOUR
//  - Reset (sync, active-high; also mid-operation): fifo_rd=0, fifo_wr=0,
//    fifo_data_in=0, error=0, rr_ptr=0, valid_d=0. Any in-flight word is dropped.
//  - stall = |almost_full. Grant (combinational from registered state, gated by reset):
//    if !stall and fifo_empty!=4'b1111: g = first i with !fifo_empty[i], searching
//    rr_ptr, rr_ptr+1, ... (mod 4); fifo_rd = 1<<g; at posedge rr_ptr<=(g+1)%4.
//    Otherwise fifo_rd=0, rr_ptr holds.
//  - Pipeline regs: valid_d<=|fifo_rd, src_d<=g (1-cycle read latency of upstream FIFO).
//  - Cycle after a pop (valid_d=1): w = fifo_data_out[src_d];
//    dest = w[WORD_SIZE-1 -: 2]; fifo_data_in = w; fifo_wr = 1<<dest.
//    If fifo_full[dest]=1: fifo_wr=0 (word dropped), error<=1.
//    Latency pop->push = 1 cycle; throughput 1 word/cycle.
//  - fifo_data_in holds last pushed value when valid_d=0; fifo_wr=0 then.
//  - Stall does not cancel the in-flight word: a word popped in cycle t is pushed in
//    t+1 even if almost_full rises in t+1 (thresholds leave >=1 slot margin).
//  - Pop and push occur in the same cycle (pipelined); no bubble between grants.
//  - A FIFO emptied by the last pop is skipped next cycle by its own empty flag;
//    the arbiter never asserts fifo_rd[i] while fifo_empty[i]=1.
//  - rr_ptr wraps 3->0. error clears only on reset.
//  - States: IDLE (no grant: all empty or stall) / XFER (grant this cycle);
//    IDLE->XFER when !stall & any non-empty; XFER->IDLE otherwise; reset->IDLE.
// TESTING
//  1. reset=1 for 3 cycles, fifo_empty=4'b0000 -> fifo_rd=0, fifo_wr=0,
//     fifo_data_in=0, error=0 throughout.
//  2. only FIFO2 non-empty, word 6'h15 (dest 1) -> cycle t fifo_rd=4'b0100;
//     t+1 fifo_wr=4'b0010, fifo_data_in=6'h15.
//  3. all four non-empty continuously, rr_ptr=0 -> fifo_rd sequence
//     0001,0010,0100,1000,0001; each push one cycle after its pop.
//  4. almost_full=4'b1000 raised while all non-empty -> fifo_rd=0 next cycle on,
//     last popped word still pushed; drop almost_full -> grants resume at saved rr_ptr.
//  5. word 6'h3A (dest 3) arrives with fifo_full=4'b1000 -> fifo_wr=0, error=1,
//     stays 1 until reset.
//  6. reset asserted the cycle after fifo_rd=4'b0001 -> next cycle fifo_wr=0,
//     rr_ptr=0; after release first grant goes to lowest-index non-empty FIFO.

Source files
------------

// File: rtl/arbitro_rr_fifo.sv
// Round-robin router between four upstream FIFOs and four downstream FIFOs.
// One word per cycle is popped from a non-empty upstream FIFO (rotating
// priority) and pushed, one cycle later, into the downstream FIFO selected
// by the word's two MSBs. Any downstream almost_full stalls all pops.
module arbitro_rr_fifo #(
    parameter int WORD_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           fifo_empty,
    input  logic [WORD_SIZE-1:0] fifo_data_out0,
    input  logic [WORD_SIZE-1:0] fifo_data_out1,
    input  logic [WORD_SIZE-1:0] fifo_data_out2,
    input  logic [WORD_SIZE-1:0] fifo_data_out3,
    input  logic [3:0]           almost_full,
    input  logic [3:0]           fifo_full,
    output logic [3:0]           fifo_rd,
    output logic [3:0]           fifo_wr,
    output logic [WORD_SIZE-1:0] fifo_data_in,
    output logic                 error
);

    // IDLE: no pop issued last cycle; XFER: a pop was issued last cycle, so
    // the upstream read data is valid now and must be pushed downstream.
    // The registered state therefore doubles as the read-latency valid bit.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [1:0]           src_q, src_d;
    logic [WORD_SIZE-1:0] last_q, last_d;
    logic                 error_q, error_d;

    logic                 stall;
    logic                 grant_found;
    logic                 grant_vld;
    logic [1:0]           grant_idx;
    logic [WORD_SIZE-1:0] rd_word;
    logic [1:0]           dest;
    logic                 valid_d;

    assign stall   = |almost_full;
    assign valid_d = (state_q == XFER);

    // Rotating search for the first non-empty upstream FIFO starting at rr_ptr.
    always_comb begin
        logic [1:0] idx;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        idx         = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!grant_found && !fifo_empty[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Pop side: grant is suppressed by reset and by downstream backpressure.
    always_comb begin
        grant_vld = !reset && !stall && grant_found;
        fifo_rd   = 4'b0000;
        rr_ptr_d  = rr_ptr_q;
        src_d     = grant_idx;
        state_d   = IDLE;
        if (grant_vld) begin
            fifo_rd  = 4'b0001 << grant_idx;
            rr_ptr_d = grant_idx + 2'd1;
            state_d  = XFER;
        end
    end

    // Select the read data of the FIFO popped last cycle.
    always_comb begin
        case (src_q)
            2'd0:    rd_word = fifo_data_out0;
            2'd1:    rd_word = fifo_data_out1;
            2'd2:    rd_word = fifo_data_out2;
            default: rd_word = fifo_data_out3;
        endcase
        dest = rd_word[WORD_SIZE-1 -: 2];
    end

    // Push side: forward the in-flight word (even under stall), dropping it
    // and raising the sticky error if its destination is already full.
    always_comb begin
        fifo_wr      = 4'b0000;
        fifo_data_in = last_q;
        last_d       = last_q;
        error_d      = error_q;
        if (reset) begin
            fifo_data_in = '0;
        end else if (valid_d) begin
            fifo_data_in = rd_word;
            last_d       = rd_word;
            if (fifo_full[dest]) begin
                error_d = 1'b1;
            end else begin
                fifo_wr = 4'b0001 << dest;
            end
        end
    end

    assign error = error_q;

    // State register; reset drops any in-flight word and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            src_q    <= 2'd0;
            last_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            last_q   <= last_d;
            error_q  <= error_d;
        end
    end

endmodule
